// File: rtl/tmds_pkg.sv
// rtl/tmds_pkg.sv - shared TMDS symbol constants and 8-bit popcount
package tmds_pkg;

  // Control-period symbols, indexed by {c1, c0}; bit 0 is serialized first
  localparam logic [9:0] TMDS_CTRL_00 = 10'b1101010100;
  localparam logic [9:0] TMDS_CTRL_01 = 10'b0010101011;
  localparam logic [9:0] TMDS_CTRL_10 = 10'b0101010100;
  localparam logic [9:0] TMDS_CTRL_11 = 10'b1010101011;

  // The link idles on the ctrl-00 symbol while held in reset
  localparam logic [9:0] TMDS_RESET_SYM = TMDS_CTRL_00;

  // Number of ones in an 8-bit value (0..8)
  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/tmds_encoder_dvi_if.sv
// rtl/tmds_encoder_dvi_if.sv - per-channel pixel/symbol bus; disparity signal only with TMDS_DEBUG_EN
interface tmds_encoder_dvi_if
`ifdef TMDS_DEBUG_EN
  #(parameter int CNT_W = 6)
`endif
  ;

  logic       de;
  logic [7:0] din;
  logic [1:0] ctrl;
  logic [9:0] tmds;
`ifdef TMDS_DEBUG_EN
  logic signed [CNT_W-1:0] disparity;
`endif

  // Pixel source side: drives video/control, receives symbols
  modport master (
    output de,
    output din,
    output ctrl,
    input  tmds
`ifdef TMDS_DEBUG_EN
    ,
    input  disparity
`endif
  );

  // Encoder side
  modport slave (
    input  de,
    input  din,
    input  ctrl,
    output tmds
`ifdef TMDS_DEBUG_EN
    ,
    output disparity
`endif
  );

endinterface

// File: rtl/tmds_encoder_dvi.sv
// rtl/tmds_encoder_dvi.sv - DVI TMDS 8b/10b channel encoder, fixed 2-cycle pipeline
// Define TMDS_DEBUG_EN to drive the running disparity onto bus.disparity.
module tmds_encoder_dvi
  import tmds_pkg::*;
#(
  parameter int CNT_W = 6
) (
  input  logic              clk_pix,
  input  logic              rst_pix_n,
  tmds_encoder_dvi_if.slave bus
);

  localparam logic signed [CNT_W-1:0] TWO = CNT_W'(2);

  logic       [3:0]       din_ones;
  logic                   use_xnor;
  logic       [8:0]       qm_d;
  logic       [8:0]       qm_q;
  logic                   de_q;
  logic       [1:0]       ctrl_q;
  logic       [3:0]       qm_ones;
  logic       [3:0]       qm_zeros;
  logic signed [CNT_W-1:0] ones_s;
  logic signed [CNT_W-1:0] zeros_s;
  logic signed [CNT_W-1:0] bal_s;
  logic signed [CNT_W-1:0] cnt_d;
  logic signed [CNT_W-1:0] cnt_q;
  logic                   cnt_zero;
  logic                   cnt_neg;
  logic                   cnt_pos;
  logic       [9:0]       tmds_d;
  logic       [9:0]       tmds_q;

  assign din_ones = popcount8(bus.din);
  assign use_xnor = (din_ones > 4'd4) || ((din_ones == 4'd4) && !bus.din[0]);

  // Transition minimising: bit i is the parity of din[i:0], inverted on odd bits for the XNOR chain
  always_comb begin
    qm_d = '0;
    for (int i = 0; i < 8; i++) begin
      qm_d[i] = (^(bus.din & (8'hFF >> (7 - i)))) ^ (use_xnor & i[0]);
    end
    qm_d[8] = ~use_xnor;
  end

  // Stage 1 register: q_m word plus the control path delayed to match
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      qm_q   <= '0;
      de_q   <= 1'b0;
      ctrl_q <= 2'b00;
    end else begin
      qm_q   <= qm_d;
      de_q   <= bus.de;
      ctrl_q <= bus.ctrl;
    end
  end

  assign qm_ones  = popcount8(qm_q[7:0]);
  assign qm_zeros = 4'd8 - qm_ones;
  assign ones_s   = CNT_W'(qm_ones);
  assign zeros_s  = CNT_W'(qm_zeros);
  assign bal_s    = ones_s - zeros_s;
  assign cnt_zero = (cnt_q == '0);
  assign cnt_neg  = cnt_q[CNT_W-1];
  assign cnt_pos  = !cnt_zero && !cnt_neg;

  // DC balancing: choose inversion from running disparity; blanking forces cnt back to zero
  always_comb begin
    tmds_d = TMDS_RESET_SYM;
    cnt_d  = '0;
    if (de_q) begin
      if (cnt_zero || (qm_ones == qm_zeros)) begin
        tmds_d = {~qm_q[8], qm_q[8], qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
        cnt_d  = qm_q[8] ? (cnt_q + bal_s) : (cnt_q - bal_s);
      end else if ((cnt_pos && (qm_ones > qm_zeros)) || (cnt_neg && (qm_zeros > qm_ones))) begin
        tmds_d = {1'b1, qm_q[8], ~qm_q[7:0]};
        cnt_d  = cnt_q - bal_s + (qm_q[8] ? TWO : '0);
      end else begin
        tmds_d = {1'b0, qm_q};
        cnt_d  = cnt_q + bal_s - (qm_q[8] ? '0 : TWO);
      end
    end else begin
      case (ctrl_q)
        2'b00: tmds_d = TMDS_CTRL_00;
        2'b01: tmds_d = TMDS_CTRL_01;
        2'b10: tmds_d = TMDS_CTRL_10;
        2'b11: tmds_d = TMDS_CTRL_11;
        default: tmds_d = TMDS_RESET_SYM;
      endcase
    end
  end

  // Stage 2 register: symbol and the disparity that follows it
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      tmds_q <= TMDS_RESET_SYM;
      cnt_q  <= '0;
    end else begin
      tmds_q <= tmds_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.tmds = tmds_q;
`ifdef TMDS_DEBUG_EN
  assign bus.disparity = cnt_q;
`endif

endmodule

// File: tb/tb_tmds_encoder_dvi.sv
// tb/tb_tmds_encoder_dvi.sv - self-checking bench for tmds_encoder_dvi (TMDS_DEBUG_EN optional)
module tb_tmds_encoder_dvi;

  typedef struct packed {
    logic [9:0]        sym;
    logic signed [31:0] cnt;
  } enc_t;

  typedef struct packed {
    logic               de;
    logic [7:0]         din;
    logic [9:0]         sym;
    logic signed [31:0] disp;
    logic               lit_en;
    logic [9:0]         lit_sym;
    logic               lit_d_en;
    logic signed [31:0] lit_disp;
  } exp_t;

  logic clk_pix   = 1'b0;
  logic rst_pix_n = 1'b1;

  logic               lit_en   = 1'b0;
  logic [9:0]         lit_sym  = '0;
  logic               lit_d_en = 1'b0;
  logic signed [31:0] lit_disp = '0;

  int n_vec = 0;
  int n_err = 0;

  int   m_cnt;
  enc_t enc;
  exp_t nxt;
  exp_t pend;
  exp_t cur;

  always #5 clk_pix = ~clk_pix;

  tmds_encoder_dvi_if bus();

  tmds_encoder_dvi #(.CNT_W(6)) dut (
    .clk_pix  (clk_pix),
    .rst_pix_n(rst_pix_n),
    .bus      (bus)
  );

  // Reference encoder: plain integer arithmetic over the DVI rules
  function automatic enc_t model_encode(input logic de, input logic [7:0] d,
                                        input logic [1:0] c, input int cnt);
    enc_t       r;
    int         ones;
    int         n1;
    int         n0;
    logic [8:0] q;
    r = '0;
    if (!de) begin
      case (c)
        2'd0: r.sym = 10'b1101010100;
        2'd1: r.sym = 10'b0010101011;
        2'd2: r.sym = 10'b0101010100;
        default: r.sym = 10'b1010101011;
      endcase
      r.cnt = 0;
      return r;
    end
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    q    = '0;
    q[0] = d[0];
    if (ones > 4 || (ones == 4 && d[0] == 1'b0)) begin
      for (int i = 1; i < 8; i++) q[i] = ~(q[i-1] ^ d[i]);
      q[8] = 1'b0;
    end else begin
      for (int i = 1; i < 8; i++) q[i] = q[i-1] ^ d[i];
      q[8] = 1'b1;
    end
    n1 = 0;
    for (int i = 0; i < 8; i++) n1 += int'(q[i]);
    n0 = 8 - n1;
    if (cnt == 0 || n1 == n0) begin
      r.sym = {~q[8], q[8], q[8] ? q[7:0] : ~q[7:0]};
      r.cnt = cnt + (q[8] ? (n1 - n0) : (n0 - n1));
    end else if ((cnt > 0 && n1 > n0) || (cnt < 0 && n0 > n1)) begin
      r.sym = {1'b1, q[8], ~q[7:0]};
      r.cnt = cnt + (q[8] ? 2 : 0) + n0 - n1;
    end else begin
      r.sym = {1'b0, q[8], q[7:0]};
      r.cnt = cnt - (q[8] ? 0 : 2) + n1 - n0;
    end
    return r;
  endfunction

  // Receiver-side decode of a data symbol
  function automatic logic [7:0] decode(input logic [9:0] s);
    logic [7:0] d;
    logic [7:0] o;
    d    = s[9] ? ~s[7:0] : s[7:0];
    o[0] = d[0];
    for (int i = 1; i < 8; i++) o[i] = s[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    return o;
  endfunction

  function automatic exp_t reset_entry();
    exp_t e;
    e     = '0;
    e.sym = 10'h354;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  // Expected entry for the inputs presented this cycle
  always_comb begin
    enc          = model_encode(bus.de, bus.din, bus.ctrl, m_cnt);
    nxt          = '0;
    nxt.de       = bus.de;
    nxt.din      = bus.din;
    nxt.sym      = enc.sym;
    nxt.disp     = enc.cnt;
    nxt.lit_en   = lit_en;
    nxt.lit_sym  = lit_sym;
    nxt.lit_d_en = lit_d_en;
    nxt.lit_disp = lit_disp;
  end

  // Two-deep expectation pipeline matching the encoder latency
  always @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      m_cnt <= 0;
      pend  <= reset_entry();
      cur   <= reset_entry();
    end else begin
      m_cnt <= enc.cnt;
      pend  <= nxt;
      cur   <= pend;
    end
  end

  // Compare process: checks outputs away from the active edge, and right after reset assertion
  always begin
    @(negedge clk_pix or negedge rst_pix_n);
    #1;
    if (!rst_pix_n) begin
      check("reset_tmds", 32'(bus.tmds), 32'h354);
`ifdef TMDS_DEBUG_EN
      check("reset_disparity", 32'(int'($signed(bus.disparity))), 32'd0);
`endif
    end else begin
      check("tmds_model", 32'(bus.tmds), 32'(cur.sym));
      if (cur.lit_en) check("tmds_literal", 32'(bus.tmds), 32'(cur.lit_sym));
      if (cur.de) check("decode_din", 32'(decode(bus.tmds)), 32'(cur.din));
`ifdef TMDS_DEBUG_EN
      check("disparity_model", 32'(int'($signed(bus.disparity))), cur.disp);
      if (cur.lit_d_en) check("disparity_literal", 32'(int'($signed(bus.disparity))), cur.lit_disp);
      check("disparity_bound",
            32'((int'($signed(bus.disparity)) <= 8) && (int'($signed(bus.disparity)) >= -8)), 32'd1);
`endif
    end
  end

  task automatic drive(input logic de, input logic [7:0] d, input logic [1:0] c,
                       input logic le, input logic [9:0] ls, input logic lde, input int ld);
    @(negedge clk_pix);
    #2;
    bus.de   = de;
    bus.din  = d;
    bus.ctrl = c;
    lit_en   = le;
    lit_sym  = ls;
    lit_d_en = lde;
    lit_disp = ld;
  endtask

  task automatic drive_rand();
    drive(($urandom_range(0, 7) != 0), 8'($urandom), 2'($urandom), 1'b0, 10'h0, 1'b0, 0);
  endtask

  initial begin
    bus.de   = 1'b0;
    bus.din  = 8'h00;
    bus.ctrl = 2'b00;
    #1 rst_pix_n = 1'b0;

    // Held in reset with random inputs
    for (int k = 0; k < 6; k++) drive_rand();
    drive(1'b0, 8'h00, 2'b00, 1'b0, 10'h0, 1'b0, 0);
    #1 rst_pix_n = 1'b1;

    // Control symbols
    drive(1'b0, 8'hA5, 2'b00, 1'b1, 10'h354, 1'b1, 0);
    drive(1'b0, 8'h3C, 2'b01, 1'b1, 10'h0AB, 1'b1, 0);
    drive(1'b0, 8'hFF, 2'b10, 1'b1, 10'h154, 1'b1, 0);
    drive(1'b0, 8'h00, 2'b11, 1'b1, 10'h2AB, 1'b1, 0);

    // Disparity walk from cnt=0 with all-zero data
    drive(1'b1, 8'h00, 2'b00, 1'b1, 10'h100, 1'b1, -8);
    drive(1'b1, 8'h00, 2'b00, 1'b1, 10'h3FF, 1'b1, 2);
    drive(1'b1, 8'h00, 2'b00, 1'b1, 10'h100, 1'b1, -6);

    // One blanking cycle restarts the count
    drive(1'b0, 8'h00, 2'b00, 1'b1, 10'h354, 1'b1, 0);
    drive(1'b1, 8'h00, 2'b00, 1'b1, 10'h100, 1'b1, -8);

    // XNOR branch, balanced word, and the unbalanced-else branch
    drive(1'b0, 8'h00, 2'b00, 1'b1, 10'h354, 1'b1, 0);
    drive(1'b1, 8'hFF, 2'b00, 1'b1, 10'h200, 1'b1, -8);
    drive(1'b1, 8'h55, 2'b00, 1'b1, 10'h133, 1'b1, -8);
    drive(1'b1, 8'h01, 2'b00, 1'b1, 10'h1FF, 1'b1, 0);
    drive(1'b1, 8'hF0, 2'b00, 1'b1, 10'h205, 1'b1, -4);

    // Random soak
    for (int k = 0; k < 3000; k++) drive_rand();

    // Asynchronous reset off the clock edge, mid-line
    drive(1'b1, 8'h5A, 2'b00, 1'b0, 10'h0, 1'b0, 0);
    @(posedge clk_pix);
    #3 rst_pix_n = 1'b0;
    for (int k = 0; k < 3; k++) drive_rand();
    #1 rst_pix_n = 1'b1;
    drive(1'b1, 8'h00, 2'b00, 1'b1, 10'h100, 1'b1, -8);
    for (int k = 0; k < 40; k++) drive_rand();
    drive(1'b0, 8'h00, 2'b00, 1'b0, 10'h0, 1'b0, 0);
    drive(1'b0, 8'h00, 2'b00, 1'b0, 10'h0, 1'b0, 0);
    drive(1'b0, 8'h00, 2'b00, 1'b0, 10'h0, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
